// File: rtl/wptr_full_cmp_pkg.sv
// Shared helpers for the async FIFO pointer blocks: depth calculation and
// Gray/binary conversions on a wide pointer type. Narrower pointers are
// zero-extended in and truncated out by the caller.
package wptr_full_cmp_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_cmp_if.sv
// Write-port bundle of the FIFO write-pointer controller. The master side is
// the writer (request, synchronised read pointer, overflow clear); the slave
// side is the pointer/flag controller.
interface wptr_full_cmp_if #(
  parameter int ADDRSIZE = 5
) ();

  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wen;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/wptr_full_cmp_gray2bin.sv
// Gray-to-binary converter (XOR prefix from the MSB down). Shared with the
// read-side pointer block for its own level computation.
module gray2bin_comb #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic [W-1:0] bin_c;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_c = gray_i;
    for (int i = W - 2; i >= 0; i--) begin
      bin_c[i] = bin_c[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = bin_c;

endmodule

// File: rtl/wptr_full_cmp.sv
// Write-side pointer and flag controller for the async FIFO. Holds binary and
// Gray write pointers and derives full, almost-full and fill level against the
// read pointer already synchronised into wclk. Full asserts on the same edge
// that registers the DEPTH-th outstanding write; it releases only after the
// synchronised read pointer moves, so it is pessimistic, never optimistic.
module wptr_full_cmp
  import wptr_full_cmp_pkg::*;
#(
  parameter int ADDRSIZE  = 5,
  parameter int AF_MARGIN = 2
) (
  input  logic          wclk,
  input  logic          wrst,
  wptr_full_cmp_if.slave bus
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = int'(depth_of(ADDRSIZE));

  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
  // Full when the write Gray pointer equals the read Gray pointer with its two
  // MSBs inverted (one lap ahead in the doubled address space).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          waf_q,    waf_d;
  logic          wovf_q,   wovf_d;

  logic          wen_c;
  logic [PW-1:0] rbin;

  gray2bin_comb #(
    .W (PW)
  ) u_gray2bin (
    .gray_i (bus.wq2_rptr),
    .bin_o  (rbin)
  );

  // Next pointer, flag and level state from the accepted write and the synchronised read pointer.
  always_comb begin
    wen_c    = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(wen_c);
    wptr_d   = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    wlevel_d = wbin_d - rbin;
    wfull_d  = (wptr_d == (bus.wq2_rptr ^ FULL_MASK));
    waf_d    = (wlevel_d >= AF_THRESH);
    // A write attempt while full takes priority over a same-edge clear.
    if (bus.winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (bus.wovf_clr) begin
      wovf_d = 1'b0;
    end else begin
      wovf_d = wovf_q;
    end
  end

  // Register pointers and flags; reset wins over any same-edge write or clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wptr         = wptr_q;
  assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
  assign bus.wen          = wen_c;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = waf_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_cmp.sv
// Directed bench for wptr_full_cmp at ADDRSIZE=5, AF_MARGIN=2 (DEPTH=32).
module tb_wptr_full_cmp;

  logic wclk;
  logic wrst;

  int checks   = 0;
  int failures = 0;

  wptr_full_cmp_if #(.ADDRSIZE(5)) bus ();

  wptr_full_cmp #(
    .ADDRSIZE  (5),
    .AF_MARGIN (2)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [5:0] rq;
    logic       clr;
    logic       exp_wen;   // sampled before the edge
    logic [5:0] exp_wptr;  // sampled after the edge
    logic [4:0] exp_waddr;
    logic [5:0] exp_lvl;
    logic       exp_full;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [5:0] g6(input int v);
    logic [5:0] b;
    b = 6'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wptr"},  32'(bus.wptr), 0);
    chk({tag, "_waddr"}, 32'(bus.waddr), 0);
    chk({tag, "_wlevel"}, 32'(bus.wlevel), 0);
    chk({tag, "_wfull"}, 32'(bus.wfull), 0);
    chk({tag, "_waf"},   32'(bus.walmost_full), 0);
    chk({tag, "_wovf"},  32'(bus.woverflow), 0);
  endtask

  initial begin
    logic [5:0] prev_wptr;
    logic [5:0] hist [0:127];

    // rows continue from a full FIFO: wbin=32, read pointer at 0
    tbl[0]  = '{1'b1, 6'b000000, 1'b0, 1'b0, 6'b110000, 5'd0, 6'd32, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 6'b000000, 1'b0, 1'b0, 6'b110000, 5'd0, 6'd32, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 6'b000000, 1'b1, 1'b0, 6'b110000, 5'd0, 6'd32, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 6'b000000, 1'b1, 1'b0, 6'b110000, 5'd0, 6'd32, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 6'b000000, 1'b1, 1'b0, 6'b110000, 5'd0, 6'd32, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 6'b000001, 1'b0, 1'b0, 6'b110000, 5'd0, 6'd31, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 6'b000010, 1'b0, 1'b0, 6'b110000, 5'd0, 6'd29, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 6'b000010, 1'b0, 1'b1, 6'b110001, 5'd1, 6'd30, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 6'b000010, 1'b0, 1'b1, 6'b110011, 5'd2, 6'd31, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 6'b000010, 1'b0, 1'b1, 6'b110010, 5'd3, 6'd32, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 6'b000010, 1'b0, 1'b0, 6'b110010, 5'd3, 6'd32, 1'b1, 1'b1, 1'b1};

    // reset held two cycles with a write request pending
    wrst         = 1'b1;
    bus.winc     = 1'b1;
    bus.wq2_rptr = '0;
    bus.wovf_clr = 1'b0;
    step();
    step();
    chk_all_zero("reset");

    // fill 32 entries with the read pointer parked at 0
    wrst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("fill%0d_wlevel", k), 32'(bus.wlevel), 32'(k));
      chk($sformatf("fill%0d_wfull", k), 32'(bus.wfull), 32'(k == 32));
      chk($sformatf("fill%0d_waf", k), 32'(bus.walmost_full), 32'(k >= 30));
      chk($sformatf("fill%0d_wptr", k), 32'(bus.wptr), 32'(g6(k)));
    end
    chk("fill_wptr_gray32", 32'(bus.wptr), 32'h30);

    // overflow, clear, and drain sequence from full
    for (int r = 0; r < 11; r++) begin
      bus.winc     = tbl[r].winc;
      bus.wq2_rptr = tbl[r].rq;
      bus.wovf_clr = tbl[r].clr;
      #1;
      chk($sformatf("row%0d_wen", r), 32'(bus.wen), 32'(tbl[r].exp_wen));
      step();
      chk($sformatf("row%0d_wptr", r), 32'(bus.wptr), 32'(tbl[r].exp_wptr));
      chk($sformatf("row%0d_waddr", r), 32'(bus.waddr), 32'(tbl[r].exp_waddr));
      chk($sformatf("row%0d_wlevel", r), 32'(bus.wlevel), 32'(tbl[r].exp_lvl));
      chk($sformatf("row%0d_wfull", r), 32'(bus.wfull), 32'(tbl[r].exp_full));
      chk($sformatf("row%0d_waf", r), 32'(bus.walmost_full), 32'(tbl[r].exp_af));
      chk($sformatf("row%0d_wovf", r), 32'(bus.woverflow), 32'(tbl[r].exp_ovf));
    end

    // reset from a full, overflowed state
    wrst         = 1'b1;
    bus.winc     = 1'b1;
    bus.wovf_clr = 1'b0;
    bus.wq2_rptr = '0;
    step();
    chk_all_zero("reset2");
    wrst = 1'b0;

    // wrap: 100 writes, read pointer trails the write pointer by two edges
    hist[0]   = 6'b0;
    prev_wptr = 6'b0;
    for (int k = 0; k < 100; k++) begin
      bus.winc     = 1'b1;
      bus.wq2_rptr = (k >= 1) ? hist[k-1] : 6'b0;
      step();
      hist[k+1] = bus.wptr;
      chk($sformatf("wrap%0d_onebit", k), 32'($countones(bus.wptr ^ prev_wptr)), 1);
      chk($sformatf("wrap%0d_wfull", k), 32'(bus.wfull), 0);
      chk($sformatf("wrap%0d_wlevel", k), 32'(bus.wlevel), (k == 0) ? 1 : 2);
      chk($sformatf("wrap%0d_waddr", k), 32'(bus.waddr), 32'((k + 1) % 32));
      if (k == 63) chk("wrap_wptr_at64", 32'(bus.wptr), 0);
      prev_wptr = bus.wptr;
    end
    chk("wrap_wptr_at100", 32'(bus.wptr), 32'h36);

    // mid-operation reset at level 17
    wrst         = 1'b1;
    bus.wq2_rptr = '0;
    step();
    wrst = 1'b0;
    for (int k = 0; k < 17; k++) step();
    chk("mid_wlevel17", 32'(bus.wlevel), 17);
    chk("mid_waddr17", 32'(bus.waddr), 17);
    wrst = 1'b1;
    step();
    chk_all_zero("midrst");
    wrst = 1'b0;
    #1;
    chk("resume_wen", 32'(bus.wen), 1);
    step();
    chk("resume_waddr", 32'(bus.waddr), 1);
    chk("resume_wlevel", 32'(bus.wlevel), 1);
    chk("resume_wptr", 32'(bus.wptr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
